// File: rtl/dbg_mon_access_pkg.sv
// dbg_mon_access_pkg: shared state encoding, jdo field positions and defaults for the debug monitor
package dbg_mon_access_pkg;
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  localparam int READ_NOW_BIT = 25;
  localparam int ADDR_LSB = 26;
  localparam int WDATA_LSB = 3;
  localparam int WDATA_MSB = 34;
  localparam int CLEAR_BIT = 37;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/dbg_mon_timeout.sv
// dbg_mon_timeout: clearable access-cycle counter with a one-cycle expiry pulse
module dbg_mon_timeout
  import dbg_mon_access_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= cnt + CW'(1);
  // fires on the TIMEOUT-th busy cycle; the FSM returns to IDLE, which clears the count
  assign expired = run && cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/dbg_mon_access.sv
// dbg_mon_access: debug-slave command sequencer for word reads/writes of the monitor memory
module dbg_mon_access
  import dbg_mon_access_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              cmd_overrun
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic idle, expired, done, load_addr, load_wdata, clr_flags, any_pulse;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[36:35], jdo[2:0]};
  assign idle       = state == IDLE;
  assign any_pulse  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign load_addr  = idle & take_action_ocimem_a;
  assign load_wdata = idle & ~take_action_ocimem_a & take_action_ocimem_b;
  assign clr_flags  = load_addr & jdo[CLEAR_BIT];
  dbg_mon_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk), .reset_n(reset_n), .clear(idle), .run(~idle), .expired(expired)
  );
  // expiry wins over a completion in the same cycle, so an aborted access never updates addr or MonDReg
  always_comb begin
    state_nx = state;
    done = 1'b0;
    case (state)
      IDLE: state_nx = take_action_ocimem_a ? (jdo[READ_NOW_BIT] ? RD_REQ : IDLE)
                     : take_action_ocimem_b ? WR_REQ
                     : take_no_action_ocimem_a ? RD_REQ : IDLE;
      RD_REQ: state_nx = expired ? IDLE : mem_waitrequest ? RD_REQ : RD_WAIT;
      RD_WAIT: begin
        done = mem_readdatavalid & ~expired;
        state_nx = (mem_readdatavalid | expired) ? IDLE : RD_WAIT;
      end
      WR_REQ: begin
        done = ~mem_waitrequest & ~expired;
        state_nx = (~mem_waitrequest | expired) ? IDLE : WR_REQ;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      wdata <= '0;
      MonDReg <= '0;
      monitor_error <= 1'b0;
      cmd_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_addr) addr <= jdo[ADDR_LSB +: ADDR_W];
      else if (done) addr <= addr + ADDR_W'(1);
      if (load_wdata) wdata <= jdo[WDATA_MSB:WDATA_LSB];
      if (done && state == RD_WAIT) MonDReg <= mem_readdata;
      if (clr_flags) begin
        monitor_error <= 1'b0;
        cmd_overrun <= 1'b0;
      end else begin
        if (expired) monitor_error <= 1'b1;
        if (!idle && any_pulse) cmd_overrun <= 1'b1;
      end
    end
  assign mem_address    = addr;
  assign mem_read       = state == RD_REQ;
  assign mem_write      = state == WR_REQ;
  assign mem_writedata  = wdata;
  assign mem_byteenable = 4'hF;
  assign monitor_ready  = idle;
endmodule

// File: tb/tb_dbg_mon_access.sv
// tb_dbg_mon_access: directed self-checking bench for dbg_mon_access
module tb_dbg_mon_access;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic a = 1'b0, na = 1'b0, b = 1'b0;
  logic [7:0] mem_address;
  logic mem_read, mem_write, mem_waitrequest = 1'b0, mem_readdatavalid = 1'b0;
  logic [31:0] mem_writedata, mem_readdata = '0, MonDReg;
  logic [3:0] mem_byteenable;
  logic monitor_ready, monitor_error, cmd_overrun;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  dbg_mon_access dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(a), .take_no_action_ocimem_a(na), .take_action_ocimem_b(b),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .cmd_overrun(cmd_overrun)
  );

  function automatic logic [37:0] ja(input logic clr, input logic [7:0] ad, input logic rn);
    ja = '0;
    ja[37] = clr;
    ja[33:26] = ad;
    ja[25] = rn;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    jb = '0;
    jb[34:3] = d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic pa, input logic pb, input logic pn, input logic [37:0] j);
    jdo = j; a = pa; b = pb; na = pn;
    step();
    a = 1'b0; b = 1'b0; na = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", monitor_ready); end
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
    n_cmp++; if (mem_address !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", mem_address); end
    n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
    n_cmp++; if ({monitor_error, cmd_overrun} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {monitor_error, cmd_overrun}); end
    n_cmp++; if (mem_byteenable !== 4'hF) begin n_err++; $display("FAIL reset_be: got %h want F", mem_byteenable); end
    reset_n = 1'b1;
  endtask

  task automatic test_addr_load();
    pulse(1, 0, 0, ja(0, 8'h10, 0));
    n_cmp++; if (mem_address !== 8'h10) begin n_err++; $display("FAIL load_addr: got %h want 10", mem_address); end
    n_cmp++; if ({mem_read, mem_write, monitor_ready} !== 3'b001) begin n_err++; $display("FAIL load_idle: rd/wr/rdy got %b want 001", {mem_read, mem_write, monitor_ready}); end
  endtask

  task automatic test_read();
    mem_waitrequest = 1'b1;
    pulse(1, 0, 0, ja(0, 8'h10, 1));
    n_cmp++; if ({mem_read, monitor_ready, mem_address} !== {2'b10, 8'h10}) begin n_err++; $display("FAIL rd_req: rd/rdy/addr got %b/%b/%h want 1/0/10", mem_read, monitor_ready, mem_address); end
    step();
    n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rd_hold: got %b want 1", mem_read); end
    mem_waitrequest = 1'b0;
    step();
    n_cmp++; if ({mem_read, monitor_ready} !== 2'b00) begin n_err++; $display("FAIL rd_wait: rd/rdy got %b want 00", {mem_read, monitor_ready}); end
    mem_readdatavalid = 1'b1; mem_readdata = 32'hDEADBEEF;
    step();
    mem_readdatavalid = 1'b0;
    n_cmp++; if (MonDReg !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want DEADBEEF", MonDReg); end
    n_cmp++; if ({monitor_ready, mem_address} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL rd_next: rdy/addr got %b/%h want 1/11", monitor_ready, mem_address); end
    pulse(0, 0, 1, '0);
    n_cmp++; if ({mem_read, mem_address} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL rd2_req: rd/addr got %b/%h want 1/11", mem_read, mem_address); end
    step();
    mem_readdatavalid = 1'b1; mem_readdata = 32'hCAFEF00D;
    step();
    mem_readdatavalid = 1'b0;
    n_cmp++; if ({MonDReg, mem_address, monitor_ready} !== {32'hCAFEF00D, 8'h12, 1'b1}) begin n_err++; $display("FAIL rd2_done: data/addr/rdy got %h/%h/%b want CAFEF00D/12/1", MonDReg, mem_address, monitor_ready); end
    mem_readdatavalid = 1'b1; mem_readdata = 32'h11111111;
    step();
    mem_readdatavalid = 1'b0;
    n_cmp++; if ({MonDReg, mem_address} !== {32'hCAFEF00D, 8'h12}) begin n_err++; $display("FAIL stray_valid: data/addr got %h/%h want CAFEF00D/12", MonDReg, mem_address); end
  endtask

  task automatic test_write_wrap();
    pulse(1, 0, 0, ja(0, 8'hFF, 0));
    mem_waitrequest = 1'b1;
    pulse(0, 1, 0, jb(32'h12345678));
    n_cmp++; if ({mem_write, mem_read, mem_address} !== {2'b10, 8'hFF}) begin n_err++; $display("FAIL wr_req: wr/rd/addr got %b/%b/%h want 1/0/FF", mem_write, mem_read, mem_address); end
    n_cmp++; if ({mem_writedata, mem_byteenable} !== {32'h12345678, 4'hF}) begin n_err++; $display("FAIL wr_data: data/be got %h/%h want 12345678/F", mem_writedata, mem_byteenable); end
    mem_waitrequest = 1'b0;
    step();
    n_cmp++; if ({mem_write, monitor_ready, mem_address} !== {2'b01, 8'h00}) begin n_err++; $display("FAIL wr_wrap: wr/rdy/addr got %b/%b/%h want 0/1/00", mem_write, monitor_ready, mem_address); end
  endtask

  task automatic test_priority();
    pulse(1, 1, 1, ja(0, 8'h20, 0));
    n_cmp++; if ({mem_address, mem_read, mem_write, monitor_ready, cmd_overrun} !== {8'h20, 4'b0010}) begin n_err++; $display("FAIL prio_a: addr/rd/wr/rdy/ovr got %h/%b want 20/0010", mem_address, {mem_read, mem_write, monitor_ready, cmd_overrun}); end
    n_cmp++; if (mem_writedata !== 32'h12345678) begin n_err++; $display("FAIL prio_wdata: got %h want 12345678", mem_writedata); end
    mem_waitrequest = 1'b1;
    pulse(0, 1, 1, jb(32'hA5A5A5A5));
    n_cmp++; if ({mem_write, mem_read, mem_writedata} !== {2'b10, 32'hA5A5A5A5}) begin n_err++; $display("FAIL prio_b: wr/rd/data got %b/%b/%h want 1/0/A5A5A5A5", mem_write, mem_read, mem_writedata); end
    mem_waitrequest = 1'b0;
    step();
    n_cmp++; if ({mem_address, cmd_overrun} !== {8'h21, 1'b0}) begin n_err++; $display("FAIL prio_done: addr/ovr got %h/%b want 21/0", mem_address, cmd_overrun); end
  endtask

  task automatic test_timeout();
    int n;
    mem_waitrequest = 1'b1;
    pulse(1, 0, 0, ja(0, 8'h40, 1));
    n = 0;
    while (mem_read === 1'b1 && n < 300) begin
      n++;
      step();
    end
    n_cmp++; if (n !== 255) begin n_err++; $display("FAIL to_cycles: read high %0d cycles want 255", n); end
    n_cmp++; if ({monitor_error, monitor_ready, mem_read} !== 3'b110) begin n_err++; $display("FAIL to_flags: err/rdy/rd got %b want 110", {monitor_error, monitor_ready, mem_read}); end
    n_cmp++; if ({mem_address, MonDReg} !== {8'h40, 32'hCAFEF00D}) begin n_err++; $display("FAIL to_state: addr/data got %h/%h want 40/CAFEF00D", mem_address, MonDReg); end
    mem_waitrequest = 1'b0;
    pulse(1, 0, 0, ja(1, 8'h41, 0));
    n_cmp++; if ({monitor_error, mem_address} !== {1'b0, 8'h41}) begin n_err++; $display("FAIL to_clear: err/addr got %b/%h want 0/41", monitor_error, mem_address); end
  endtask

  task automatic test_overrun_reset();
    pulse(0, 0, 1, '0);
    step();
    pulse(0, 1, 0, jb(32'hFFFFFFFF));
    n_cmp++; if ({cmd_overrun, mem_write, monitor_ready} !== 3'b100) begin n_err++; $display("FAIL overrun: ovr/wr/rdy got %b want 100", {cmd_overrun, mem_write, monitor_ready}); end
    mem_readdatavalid = 1'b1; mem_readdata = 32'h55AA55AA;
    step();
    mem_readdatavalid = 1'b0;
    n_cmp++; if ({MonDReg, mem_address, mem_writedata} !== {32'h55AA55AA, 8'h42, 32'hA5A5A5A5}) begin n_err++; $display("FAIL ovr_read: data/addr/wdata got %h/%h/%h want 55AA55AA/42/A5A5A5A5", MonDReg, mem_address, mem_writedata); end
    mem_waitrequest = 1'b1;
    pulse(0, 0, 1, '0);
    n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rst_pre: rd got %b want 1", mem_read); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({mem_read, mem_write, monitor_ready, monitor_error, cmd_overrun} !== 5'b00100) begin n_err++; $display("FAIL rst_mid_ctl: got %b want 00100", {mem_read, mem_write, monitor_ready, monitor_error, cmd_overrun}); end
    n_cmp++; if ({mem_address, MonDReg, mem_writedata} !== '0) begin n_err++; $display("FAIL rst_mid_data: addr/data/wdata got %h/%h/%h want 0", mem_address, MonDReg, mem_writedata); end
    mem_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pulse(1, 0, 0, ja(0, 8'h33, 0));
    n_cmp++; if ({mem_address, monitor_ready} !== {8'h33, 1'b1}) begin n_err++; $display("FAIL rst_first_cmd: addr/rdy got %h/%b want 33/1", mem_address, monitor_ready); end
  endtask

  initial begin
    test_reset();
    test_addr_load();
    test_read();
    test_write_wrap();
    test_priority();
    test_timeout();
    test_overrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
